multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multicycle phase sequencer for the MIPS core. Consumes the decoded control bundle from the instruction decoder and steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Drives the per-phase register enables, the PC source select, the ALU command and the single-port memory request handshake. Sits between the decoder and the datapath, with one instance per core.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- exec_cmd  in  4  decoded ALU command; sampled in DECODE
- mem_r_en  in  1  decoded load flag; sampled in DECODE
- mem_w_en  in  1  decoded store flag; sampled in DECODE
- wb_en  in  1  decoded register write-back flag; sampled in DECODE
- is_imm  in  1  decoded immediate-operand flag; sampled in DECODE
- branch_type  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP; sampled in DECODE
- val1_zero  in  1  operand 1 equals zero; sampled in EXEC
- vals_eq  in  1  operand 1 equals operand 2; sampled in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- state  out  3  current phase: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
- ir_we  out  1  load the instruction register
- pc_we  out  1  load the PC
- pc_src  out  1  0 selects PC+1, 1 selects the branch target
- alu_cmd  out  4  latched exec_cmd
- alu_b_imm  out  1  latched is_imm
- alu_out_we  out  1  load the ALU result register
- mem_req  out  1  memory request
- mem_we  out  1  request is a write
- rf_we  out  1  register file write
- wb_sel_mem  out  1  write-back data comes from memory
- instr_done  out  1  one-cycle pulse when an instruction retires
- retired_cnt  out  CNT_W  retired instruction count
- stall_cnt  out  CNT_W  memory wait-cycle count

## Operation
- The state register and the latched control bundle are registered. All other outputs are combinational from state, the latched bundle, mem_ready, val1_zero and vals_eq.
- FETCH:
  - mem_req=1, mem_we=0.
  - On the cycle mem_ready=1: ir_we=1, pc_we=1, pc_src=0, and the next state is DECODE.
  - Otherwise the sequencer stays in FETCH.
- DECODE:
  - Lasts exactly one cycle.
  - Latches exec_cmd, mem_r_en, mem_w_en, wb_en, is_imm and branch_type.
  - Next state is EXEC.
- EXEC:
  - Lasts exactly one cycle; alu_out_we=1.
  - The branch is taken when branch_type is 01 with val1_zero=1, or 10 with vals_eq=0, or 11.
  - When taken: pc_we=1 and pc_src=1.
  - Next state:
    - MEM if the latched mem_r_en or mem_w_en is set.
    - Otherwise WB if the latched wb_en is set.
    - Otherwise FETCH, with instr_done=1.
- MEM:
  - mem_req=1; mem_we equals latched mem_w_en AND NOT latched mem_r_en. If both flags are set, the access is treated as a read.
  - The sequencer waits for mem_ready=1.
  - After a read, next state is WB.
  - After a write, next state is FETCH, with instr_done=1.
- WB:
  - rf_we=1, wb_sel_mem equals latched mem_r_en, instr_done=1.
  - Next state is FETCH.
- Outputs not listed for a state are 0.
- alu_cmd and alu_b_imm hold their latched values in every state.

## Timing
- Reset:
  - While rst=1, every output is 0, the state is FETCH, and the latched bundle and counters are cleared.
  - The first cycle after release asserts mem_req.
- Reset mid-operation abandons the instruction. The cycle after rst is sampled high shows all outputs at 0, and there is no instr_done.
- Minimum latency with mem_ready held at 1:
  - NOP or untaken branch: 3 cycles.
  - ALU op or store: 4 cycles.
  - Load: 5 cycles.
- Each cycle of mem_ready=0 during FETCH or MEM adds one cycle.
- mem_ready is ignored outside FETCH and MEM.
- mem_req, once raised, stays high until the cycle mem_ready=1. The request ends in that same cycle.
- At most one instr_done per instruction. Back-to-back instructions produce no bubble beyond the phases listed above.

## Configuration
- Macro: MULTICYCLE_SEQUENCER_PERF_CNT_EN.
- When defined:
  - retired_cnt increments on each instr_done.
  - stall_cnt increments on each cycle with mem_req=1 and mem_ready=0.
  - Both counters wrap from 2^CNT_W-1 to 0 and clear on rst.
- When undefined:
  - Both ports are tied to 0 and no counter registers are built.

## Test plan
- Hold rst=1 for 3 cycles with mem_ready=1: all outputs 0. The first cycle after release shows state=0 and mem_req=1.
- ADD (exec_cmd=0000, wb_en=1) with mem_ready=1: state sequence 0,1,2,4,0. alu_cmd=0000 with alu_out_we=1 in EXEC. rf_we=1 and instr_done=1 in WB only.
- LD (mem_r_en=1, wb_en=1, is_imm=1) with mem_ready=0 for 3 cycles in MEM:
  - mem_req is high for 4 cycles in MEM with mem_we=0.
  - WB shows wb_sel_mem=1.
  - Total 8 cycles; stall_cnt +3 when the macro is defined.
- BNE with vals_eq=0: EXEC shows pc_we=1 and pc_src=1, and the next state is FETCH with instr_done. Repeat with vals_eq=1: EXEC shows pc_we=0.
- ST with rst asserted during the MEM wait: the next cycle shows all outputs 0, there is no instr_done, and retired_cnt=0.
- CNT_W=4, macro defined, 16 NOPs with mem_ready=1: retired_cnt reads 15 after the 15th instruction and 0 after the 16th.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB phase sequencer for the MIPS core.
// Optional performance counters are built when MULTICYCLE_SEQUENCER_PERF_CNT_EN is defined.
module multicycle_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       exec_cmd,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic             wb_en,
    input  logic             is_imm,
    input  logic [1:0]       branch_type,
    input  logic             val1_zero,
    input  logic             vals_eq,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic [3:0]       alu_cmd,
    output logic             alu_b_imm,
    output logic             alu_out_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             rf_we,
    output logic             wb_sel_mem,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cmd_q;
    logic       rd_q, wr_q, wb_q, imm_q;
    logic [1:0] bt_q;
    logic       taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            cmd_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wb_q    <= 1'b0;
            imm_q   <= 1'b0;
            bt_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                cmd_q <= exec_cmd;
                rd_q  <= mem_r_en;
                wr_q  <= mem_w_en;
                wb_q  <= wb_en;
                imm_q <= is_imm;
                bt_q  <= branch_type;
            end
        end
    end

    // Memory handshake: mem_req stays high until the cycle mem_ready=1, which completes it.
    always_comb begin
        state_d    = state_q;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        alu_out_we = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        rf_we      = 1'b0;
        wb_sel_mem = 1'b0;
        instr_done = 1'b0;
        taken      = (bt_q == 2'b01 && val1_zero) || (bt_q == 2'b10 && !vals_eq) ||
                     (bt_q == 2'b11);
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                alu_out_we = 1'b1;
                if (taken) begin
                    pc_we  = 1'b1;
                    pc_src = 1'b1;
                end
                if (rd_q || wr_q) begin
                    state_d = MEM;
                end else if (wb_q) begin
                    state_d = WB;
                end else begin
                    state_d    = FETCH;
                    instr_done = 1'b1;
                end
            end
            MEM: begin
                // A request flagged as both load and store is performed as a load.
                mem_req = 1'b1;
                mem_we  = wr_q & ~rd_q;
                if (mem_ready) begin
                    if (rd_q) begin
                        state_d = WB;
                    end else begin
                        state_d    = FETCH;
                        instr_done = 1'b1;
                    end
                end
            end
            WB: begin
                rf_we      = 1'b1;
                wb_sel_mem = rd_q;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (rst) begin
            state_d    = FETCH;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            pc_src     = 1'b0;
            alu_out_we = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            rf_we      = 1'b0;
            wb_sel_mem = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign state     = rst ? 3'd0 : state_q;
    assign alu_cmd   = rst ? 4'd0 : cmd_q;
    assign alu_b_imm = rst ? 1'b0 : imm_q;

`ifdef MULTICYCLE_SEQUENCER_PERF_CNT_EN
    logic [CNT_W-1:0] ret_q, stall_q;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            ret_q   <= '0;
            stall_q <= '0;
        end else begin
            if (instr_done) ret_q <= ret_q + ONE;
            if (mem_req && !mem_ready) stall_q <= stall_q + ONE;
        end
    end

    assign retired_cnt = rst ? '0 : ret_q;
    assign stall_cnt   = rst ? '0 : stall_q;
`else
    assign retired_cnt = '0;
    assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction phase schedules expanded into cycle records.
module tb_multicycle_sequencer;

    localparam int CNT_W = 4;
    localparam int EXP_W = 17;

    logic             clk, rst;
    logic [3:0]       exec_cmd;
    logic             mem_r_en, mem_w_en, wb_en, is_imm;
    logic [1:0]       branch_type;
    logic             val1_zero, vals_eq, mem_ready;
    logic [2:0]       state;
    logic             ir_we, pc_we, pc_src, alu_b_imm, alu_out_we;
    logic             mem_req, mem_we, rf_we, wb_sel_mem, instr_done;
    logic [3:0]       alu_cmd;
    logic [CNT_W-1:0] retired_cnt, stall_cnt;

    multicycle_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .exec_cmd(exec_cmd), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .wb_en(wb_en), .is_imm(is_imm),
        .branch_type(branch_type), .val1_zero(val1_zero), .vals_eq(vals_eq),
        .mem_ready(mem_ready), .state(state), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .alu_cmd(alu_cmd), .alu_b_imm(alu_b_imm),
        .alu_out_we(alu_out_we), .mem_req(mem_req), .mem_we(mem_we),
        .rf_we(rf_we), .wb_sel_mem(wb_sel_mem), .instr_done(instr_done),
        .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cmd;
        logic       r, w, wb, imm;
        logic [1:0] bt;
        logic       v1z, veq;
        int         fwait, mwait;
        logic       abort;
    } instr_t;

    typedef struct {
        logic       rst, mrdy, v1z, veq;
        logic [3:0] cmd;
        logic       r, w, wb, imm;
        logic [1:0] bt;
    } stim_t;

    stim_t            stim_q[$];
    logic [EXP_W-1:0] exp_q[$];
    logic [7:0]       cnt_q[$];

    logic [3:0] m_cmd = 4'd0;
    logic       m_imm = 1'b0;
    int         m_ret = 0, m_stall = 0;
    int         checks = 0, errors = 0;

    function automatic logic rbit();
        return $urandom_range(0, 1) == 1;
    endfunction

    task automatic push(input logic rst_i, input logic mrdy, input logic v1z, input logic veq,
                        input instr_t ins, input logic dec, input logic [2:0] st,
                        input logic ir, input logic pcw, input logic src, input logic aoe,
                        input logic req, input logic mwe, input logic rf, input logic wbs,
                        input logic done);
        stim_t s;
        s.rst  = rst_i;
        s.mrdy = mrdy;
        s.v1z  = v1z;
        s.veq  = veq;
        s.cmd  = dec ? ins.cmd : 4'($urandom_range(0, 15));
        s.r    = dec ? ins.r   : rbit();
        s.w    = dec ? ins.w   : rbit();
        s.wb   = dec ? ins.wb  : rbit();
        s.imm  = dec ? ins.imm : rbit();
        s.bt   = dec ? ins.bt  : 2'($urandom_range(0, 3));
        stim_q.push_back(s);
        if (rst_i) begin
            exp_q.push_back('0);
            cnt_q.push_back(8'd0);
            m_cmd = 4'd0; m_imm = 1'b0; m_ret = 0; m_stall = 0;
        end else begin
            exp_q.push_back({st, ir, pcw, src, m_cmd, m_imm, aoe, req, mwe, rf, wbs, done});
            cnt_q.push_back({4'(m_ret), 4'(m_stall)});
            if (dec) begin
                m_cmd = ins.cmd;
                m_imm = ins.imm;
            end
            if (done) m_ret = (m_ret + 1) % 16;
            if (req && !mrdy) m_stall = (m_stall + 1) % 16;
        end
    endtask

    task automatic add_rst(input int n);
        instr_t z;
        z = '{default: 0};
        for (int k = 0; k < n; k++) push(1, 1, rbit(), rbit(), z, 0, 3'd0, 0,0,0,0,0,0,0,0,0);
    endtask

    // Expected schedule of one instruction, derived from its decoded flags.
    task automatic add_instr(input instr_t i);
        logic taken, mem, done_e;
        for (int k = 0; k < i.fwait; k++)
            push(0, 0, rbit(), rbit(), i, 0, 3'd0, 0,0,0,0,1,0,0,0,0);
        push(0, 1, rbit(), rbit(), i, 0, 3'd0, 1,1,0,0,1,0,0,0,0);
        push(0, rbit(), rbit(), rbit(), i, 1, 3'd1, 0,0,0,0,0,0,0,0,0);
        taken  = (i.bt == 2'd1 && i.v1z) || (i.bt == 2'd2 && !i.veq) || (i.bt == 2'd3);
        mem    = i.r || i.w;
        done_e = !mem && !i.wb;
        push(0, rbit(), i.v1z, i.veq, i, 0, 3'd2, 0,taken,taken,1,0,0,0,0,done_e);
        if (mem) begin
            for (int k = 0; k < i.mwait; k++)
                push(0, 0, rbit(), rbit(), i, 0, 3'd3, 0,0,0,0,1,i.w & !i.r,0,0,0);
            if (i.abort) return;
            push(0, 1, rbit(), rbit(), i, 0, 3'd3, 0,0,0,0,1,i.w & !i.r,0,0,!i.r);
        end
        if (mem ? i.r : i.wb)
            push(0, rbit(), rbit(), rbit(), i, 0, 3'd4, 0,0,0,0,0,0,1,i.r,1);
    endtask

    instr_t dir_tbl[12];

    initial begin
        stim_t s;
        logic [EXP_W-1:0] e, got;
        logic [7:0] c, gotc;
        instr_t nop, ri;
        int cyc;

        rst = 1'b1; mem_ready = 1'b1; exec_cmd = 4'd0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        wb_en = 1'b0; is_imm = 1'b0; branch_type = 2'd0; val1_zero = 1'b0; vals_eq = 1'b0;

        //            cmd   r  w  wb imm bt  v1z veq fw mw abort
        dir_tbl[0]  = '{4'h0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0};  // ADD
        dir_tbl[1]  = '{4'h5, 1, 0, 1, 1, 2'd0, 0, 0, 0, 3, 0};  // LD, 3 waits
        dir_tbl[2]  = '{4'h1, 0, 0, 0, 0, 2'd2, 0, 0, 0, 0, 0};  // BNE taken
        dir_tbl[3]  = '{4'h1, 0, 0, 0, 0, 2'd2, 0, 1, 0, 0, 0};  // BNE not taken
        dir_tbl[4]  = '{4'h2, 0, 0, 0, 0, 2'd1, 1, 0, 1, 0, 0};  // BEZ taken
        dir_tbl[5]  = '{4'h2, 0, 0, 0, 0, 2'd1, 0, 1, 0, 0, 0};  // BEZ not taken
        dir_tbl[6]  = '{4'h3, 0, 0, 0, 0, 2'd3, 0, 1, 2, 0, 0};  // JMP
        dir_tbl[7]  = '{4'h6, 0, 1, 0, 1, 2'd0, 0, 0, 0, 2, 0};  // ST
        dir_tbl[8]  = '{4'h7, 1, 1, 1, 1, 2'd0, 0, 0, 0, 1, 0};  // load+store flags: read
        dir_tbl[9]  = '{4'ha, 0, 0, 1, 1, 2'd0, 0, 0, 3, 0, 0};  // ALU imm, slow fetch
        dir_tbl[10] = '{4'h6, 0, 1, 0, 1, 2'd0, 0, 0, 0, 2, 1};  // ST aborted by reset
        dir_tbl[11] = '{4'h9, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0};  // ADD after reset

        add_rst(3);
        nop = '{4'h0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 16; k++) add_instr(nop);
        for (int k = 0; k < 12; k++) begin
            add_instr(dir_tbl[k]);
            if (dir_tbl[k].abort) add_rst(2);
        end
        for (int k = 0; k < 300; k++) begin
            ri.cmd = 4'($urandom_range(0, 15));
            ri.r = $urandom_range(0, 3) == 0;
            ri.w = $urandom_range(0, 3) == 0;
            ri.wb = rbit(); ri.imm = rbit();
            ri.bt = 2'($urandom_range(0, 3));
            ri.v1z = rbit(); ri.veq = rbit();
            ri.fwait = $urandom_range(0, 2);
            ri.mwait = $urandom_range(0, 3);
            ri.abort = 1'b0;
            add_instr(ri);
        end

        cyc = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            c = cnt_q.pop_front();
            @(negedge clk);
            rst = s.rst; mem_ready = s.mrdy; val1_zero = s.v1z; vals_eq = s.veq;
            exec_cmd = s.cmd; mem_r_en = s.r; mem_w_en = s.w; wb_en = s.wb;
            is_imm = s.imm; branch_type = s.bt;
            #1;
            got = {state, ir_we, pc_we, pc_src, alu_cmd, alu_b_imm, alu_out_we,
                   mem_req, mem_we, rf_we, wb_sel_mem, instr_done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL cyc %0d outputs got %h exp %h", cyc, got, e);
            end
`ifdef MULTICYCLE_SEQUENCER_PERF_CNT_EN
            gotc = {retired_cnt, stall_cnt};
`else
            gotc = {retired_cnt, stall_cnt};
            c = 8'd0;
`endif
            checks++;
            if (gotc !== c) begin
                errors++;
                $display("FAIL cyc %0d counters got %h exp %h", cyc, gotc, c);
            end
            cyc++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
